// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, two write ports and the scoreboard set port.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0] raddr1;
  logic [DATA_W-1:0] rdata1;
  logic              rbusy1;
  logic [ADDR_W-1:0] raddr2;
  logic [DATA_W-1:0] rdata2;
  logic              rbusy2;
  logic              we_a;
  logic [ADDR_W-1:0] waddr_a;
  logic [DATA_W-1:0] wdata_a;
  logic              we_b;
  logic [ADDR_W-1:0] waddr_b;
  logic [DATA_W-1:0] wdata_b;
  logic              busy_set;
  logic [ADDR_W-1:0] busy_addr;

  modport master (
    output raddr1, raddr2, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b,
           busy_set, busy_addr,
    input  rdata1, rbusy1, rdata2, rbusy2
  );

  modport slave (
    input  raddr1, raddr2, we_a, waddr_a, wdata_a, we_b, waddr_b, wdata_b,
           busy_set, busy_addr,
    output rdata1, rbusy1, rdata2, rbusy2
  );
endinterface

// File: rtl/regfile_mp.sv
// Two-read / two-write register file with optional bypass, hardwired zero
// entry, per-entry busy scoreboard and a sequenced post-reset storage clear.
// Note: reset_n is active HIGH despite its name (legacy port naming).
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  output logic         init_done,
  regfile_mp_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [ADDR_W-1:0] clr_ptr;

  logic wa_ok, wb_ok, bs_ok;
  logic [ADDR_W-1:0] raddr [2];
  logic [DATA_W-1:0] rdata [2];
  logic              rbusy [2];

  // Writes and busy sets are only honoured after init; entry 0 is immune when hardwired.
  assign wa_ok = init_done && bus.we_a     && !((ZERO_REG != 0) && (bus.waddr_a == '0));
  assign wb_ok = init_done && bus.we_b     && !((ZERO_REG != 0) && (bus.waddr_b == '0));
  assign bs_ok = init_done && bus.busy_set && !((ZERO_REG != 0) && (bus.busy_addr == '0));

  // Storage: one entry cleared per edge during init, then A/B writes (B assigned last so it wins).
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      if (!init_done) begin
        mem[clr_ptr] <= '0;
      end else begin
        if (wa_ok) mem[bus.waddr_a] <= bus.wdata_a;
        if (wb_ok) mem[bus.waddr_b] <= bus.wdata_b;
      end
    end
  end

  // Init sequencing and scoreboard; set assigned after clear so a new producer wins.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      init_done <= 1'b0;
      clr_ptr   <= '0;
      busy      <= '0;
    end else if (!init_done) begin
      clr_ptr <= clr_ptr + 1'b1;
      if (clr_ptr == '1) init_done <= 1'b1;
    end else begin
      if (wb_ok) busy[bus.waddr_b]   <= 1'b0;
      if (bs_ok) busy[bus.busy_addr] <= 1'b1;
    end
  end

  assign raddr[0] = bus.raddr1;
  assign raddr[1] = bus.raddr2;

  // Read mux per port: zero entry, then B bypass, then A bypass, then array.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rdata[p] = '0;
      rbusy[p] = 1'b0;
      if (init_done) begin
        rbusy[p] = busy[raddr[p]];
        if ((ZERO_REG != 0) && (raddr[p] == '0))
          rdata[p] = '0;
        else if ((BYPASS != 0) && bus.we_b && (bus.waddr_b == raddr[p]))
          rdata[p] = bus.wdata_b;
        else if ((BYPASS != 0) && bus.we_a && (bus.waddr_a == raddr[p]))
          rdata[p] = bus.wdata_a;
        else
          rdata[p] = mem[raddr[p]];
      end
    end
  end

  assign bus.rdata1 = rdata[0];
  assign bus.rbusy1 = rbusy[0];
  assign bus.rdata2 = rdata[1];
  assign bus.rbusy2 = rbusy[1];
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised successor to the single-write register file; sits between decode and execute/writeback.
- Two combinational read ports. Two write ports: A is the ALU writeback, B is the long-latency/load writeback.
- Optional write-to-read bypass and hardwired-zero entry 0.
- Per-entry busy scoreboard for in-flight long-latency results.
- Sequenced post-reset clear of storage, signalled by init_done.

Parameters:
- DATA_W, 32, data width of each entry.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W (derived localparam, not overridable).
- ZERO_REG, 1, 1 = entry 0 reads 0 and ignores writes and busy_set.
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads see array only.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset_n  in  1  synchronous, active-high reset; the name follows the existing port naming, but polarity is high.
- init_done  out  1  high once storage clear has completed.
- raddr1  in  ADDR_W  read port 1 address.
- rdata1  out  DATA_W  read port 1 data, combinational.
- rbusy1  out  1  busy bit of raddr1, combinational from the busy register.
- raddr2  in  ADDR_W  read port 2 address.
- rdata2  out  DATA_W  read port 2 data, combinational.
- rbusy2  out  1  busy bit of raddr2.
- we_a  in  1  write enable, port A.
- waddr_a  in  ADDR_W  write address, port A.
- wdata_a  in  DATA_W  write data, port A.
- we_b  in  1  write enable, port B; also clears busy.
- waddr_b  in  ADDR_W  write address, port B.
- wdata_b  in  DATA_W  write data, port B.
- busy_set  in  1  mark busy_addr busy.
- busy_addr  in  ADDR_W  scoreboard set address.

Behaviour:

Reset and initialisation
- reset_n sampled high at an edge sets:
  - init_done <= 0
  - clear pointer <= 0
  - all busy bits <= 0
- Storage is not bulk-cleared in that cycle.
- Clear sequence: at each edge with reset_n low and init_done low, entry[ptr] <= 0 and ptr++.
- First low edge clears entry 0; the edge clearing entry DEPTH-1 also sets init_done <= 1. init_done therefore rises exactly DEPTH edges after reset release.
- Reset reasserted mid-clear restarts the sequence from entry 0.
- While init_done = 0:
  - we_a, we_b and busy_set are ignored.
  - rdata1, rdata2, rbusy1 and rbusy2 are driven 0.

Reads
- Combinational, zero latency.
- Priority, per port:
  - ZERO_REG and addr = 0 -> 0.
  - else BYPASS and we_b and waddr_b == raddr -> wdata_b.
  - else BYPASS and we_a and waddr_a == raddr -> wdata_a.
  - else array[raddr].
- rbusy reflects the registered busy bit only; a set or clear in the current cycle is visible from the next cycle.

Writes
- Committed at the rising edge.
- we_a and we_b to the same address in the same cycle: port B data wins.
- Writes to address 0 are dropped when ZERO_REG = 1.
- Different addresses on A and B are both written in the same cycle.

Scoreboard
- busy_set -> busy[busy_addr] <= 1.
- we_b -> busy[waddr_b] <= 0.
- Same address, same cycle, set and clear: set wins (a new producer was issued).
- we_a never touches busy.
- busy_set on an already-busy entry leaves it 1.
- we_b to a non-busy entry writes normally.
- busy_set to address 0 is ignored when ZERO_REG = 1.

Width rules
- No arithmetic on data.
- Address compares are full ADDR_W; all addresses are in range by construction.

Test Plan:
1. Init: reset high 2 cycles, then low.
   - init_done must be 0 for exactly DEPTH = 32 edges and rise on the 32nd.
   - rdata1 = 0 throughout.
   - we_a to reg 3 with 0xDEAD during init -> reg 3 reads 0 after init.
2. Bypass and dual write: with BYPASS = 1, same cycle we_a to reg 5 = 0x11 and we_b to reg 5 = 0x22, raddr1 = 5.
   - rdata1 = 0x22 in that cycle.
   - Next cycle rdata1 = 0x22.
   - With BYPASS = 0, rdata1 = old value in the write cycle.
3. Zero register: we_a to reg 0 = 0xFFFF_FFFF, busy_set to addr 0 -> rdata = 0, rbusy = 0.
4. Scoreboard: busy_set reg 7 -> rbusy1 = 1 next cycle.
   - we_a to reg 7 -> still 1.
   - we_b to reg 7 = 0x77 -> rbusy1 = 0 next cycle, rdata1 = 0x77.
   - Simultaneous busy_set and we_b on reg 9 -> busy = 1.
5. Reset mid-clear: reassert reset at the 10th clear edge, release -> init_done rises 32 edges after the second release, and all busy bits = 0.
